// File: rtl/rmii_stream_bridge.sv
// RMII PHY pins <-> MAC valid/ready word stream at 10/100 Mb/s, all on the 50 MHz reference clock.
// Build macro RMII_PREAMBLE_STRIP_EN: RX drops preamble and SFD before delivering words.
module rmii_stream_bridge #(
  parameter int MAC_W         = 8,
  parameter int RX_FIFO_DEPTH = 8,
  parameter int IFG_DIBITS    = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             speed_10,
  input  logic [1:0]       phy_rxd,
  input  logic             phy_crs_dv,
  output logic [1:0]       phy_txd,
  output logic             phy_tx_en,
  output logic [MAC_W-1:0] rx_data,
  output logic             rx_last,
  output logic             rx_err,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [MAC_W-1:0] tx_data,
  input  logic             tx_last,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             rx_overflow,
  output logic             tx_underrun
);
  localparam logic [1:0] LAST_POS = 2'(MAC_W / 2 - 1);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = $clog2(IFG_DIBITS + 1);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(RX_FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_M1 = (AW + 1)'(RX_FIFO_DEPTH - 1);
`ifdef RMII_PREAMBLE_STRIP_EN
  localparam logic STRIP = 1'b1;
`else
  localparam logic STRIP = 1'b0;
`endif

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_FLUSH, TX_GAP} tx_state_t;

  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;
  logic speed_q, speed_d, run_q;
  logic [3:0] cnt_q, cnt_d;
  logic strobe, rx_start, rx_end, load_slot;
  logic [MAC_W-1:0] w_q, w_d, pend_q, pend_d, wnew, push_data;
  logic [1:0] pos_q, pos_d;
  logic pend_vld_q, pend_vld_d, sfd_q, sfd_d, ferr_q, ferr_d;
  logic push, push_last, push_err, pop, accept, ovf_q, ovf_d;
  logic [MAC_W+1:0] mem [RX_FIFO_DEPTH];
  logic [MAC_W+1:0] rd_entry;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] fcnt_q, fcnt_d, occ;
  logic [MAC_W-1:0] sh_q, sh_d;
  logic [1:0] dpos_q, dpos_d, txd_q, txd_d;
  logic tlast_q, tlast_d, txen_q, txen_d, urun_q, urun_d;
  logic [CW-1:0] gap_q, gap_d;

  assign strobe    = !speed_q || (cnt_q == 4'd0);
  assign rx_start  = (rx_state_q == RX_IDLE) && strobe && phy_crs_dv && (phy_rxd == 2'b01);
  // CRS_DV may drop mid-nibble on carrier loss; the frame only closes on a nibble boundary.
  assign rx_end    = (rx_state_q == RX_RECV) && strobe && !phy_crs_dv && (!sfd_q || !pos_q[0]);
  assign load_slot = ((tx_state_q == TX_IDLE) && strobe) ||
                     ((tx_state_q == TX_SEND) && strobe && (dpos_q == LAST_POS) && !tlast_q) ||
                     (tx_state_q == TX_FLUSH);
  assign tx_ready  = run_q && load_slot;

  always_comb begin
    speed_d = speed_q;
    cnt_d   = cnt_q;
    if (speed_q) cnt_d = (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
    if ((rx_state_q == RX_IDLE) && (tx_state_q == TX_IDLE) && !rx_start &&
        !(tx_ready && tx_valid) && (speed_10 != speed_q)) begin
      speed_d = speed_10;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      tx_state_q <= TX_IDLE;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    if (rx_start) rx_state_d = RX_RECV;
    else if (rx_end) rx_state_d = RX_IDLE;
  end

  // Pending is flushed as a data word once a dibit of the next word shows up, so a partial
  // trailing word and the pending word never need pushing in the same cycle.
  always_comb begin
    w_d = w_q; pos_d = pos_q; pend_d = pend_q; pend_vld_d = pend_vld_q; sfd_d = sfd_q;
    push = 1'b0; push_last = 1'b0; push_err = 1'b0; push_data = pend_q;
    wnew = (pos_q == 2'd0) ? '0 : w_q;
    wnew[2*pos_q +: 2] = phy_rxd;
    if (rx_start) begin
      pend_vld_d = 1'b0;
      sfd_d      = !STRIP;
      w_d        = '0;
      w_d[1:0]   = STRIP ? 2'b00 : 2'b01;
      pos_d      = STRIP ? 2'd0 : 2'd1;
    end else if (rx_end) begin
      pend_vld_d = 1'b0;
      if (pos_q != 2'd0) begin
        push = 1'b1; push_last = 1'b1; push_err = 1'b1; push_data = w_q;
      end else if (pend_vld_q) begin
        push = 1'b1; push_last = 1'b1;
      end
    end else if ((rx_state_q == RX_RECV) && strobe) begin
      if (!sfd_q) begin
        if (phy_rxd == 2'b11) sfd_d = 1'b1;
      end else begin
        if ((pos_q == 2'd0) && pend_vld_q) begin
          push = 1'b1; pend_vld_d = 1'b0;
        end
        w_d = wnew;
        if (pos_q == LAST_POS) begin
          pend_d = wnew; pend_vld_d = 1'b1; pos_d = 2'd0;
        end else begin
          pos_d = pos_q + 2'd1;
        end
      end
    end
  end

  // The last slot is held back for the word that closes the frame.
  assign pop = rx_valid && rx_ready;
  assign occ = fcnt_q - {{AW{1'b0}}, pop};
  always_comb begin
    accept = push && (push_last ? (occ < DEPTH_C) : (occ < DEPTH_M1));
    ovf_d  = push && !accept;
    ferr_d = ferr_q;
    if (ovf_d) ferr_d = 1'b1;
    if ((push && push_last) || rx_start) ferr_d = 1'b0;
    wp_d   = accept ? wp_q + 1'b1 : wp_q;
    rp_d   = pop ? rp_q + 1'b1 : rp_q;
    fcnt_d = fcnt_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wp_q] <= {push_err | (push_last & ferr_q), push_last, push_data};
  end

  assign rd_entry    = mem[rp_q];
  assign rx_valid    = (fcnt_q != '0);
  assign rx_data     = rx_valid ? rd_entry[MAC_W-1:0] : '0;
  assign rx_last     = rx_valid && rd_entry[MAC_W];
  assign rx_err      = rx_valid && rd_entry[MAC_W+1];
  assign rx_overflow = ovf_q;

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TX_IDLE:  if (tx_ready && tx_valid) tx_state_d = TX_SEND;
      TX_SEND:  if (strobe && (dpos_q == LAST_POS)) begin
                  if (tlast_q) tx_state_d = TX_GAP;
                  else if (!tx_valid) tx_state_d = TX_FLUSH;
                end
      TX_FLUSH: if (tx_valid && tx_last) tx_state_d = TX_GAP;
      TX_GAP:   if (strobe && (gap_q == CW'(IFG_DIBITS - 1))) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    sh_d = sh_q; dpos_d = dpos_q; tlast_d = tlast_q; txd_d = txd_q; txen_d = txen_q;
    gap_d = gap_q; urun_d = 1'b0;
    if (tx_ready && tx_valid && (tx_state_q != TX_FLUSH)) begin
      sh_d = tx_data; dpos_d = 2'd0; tlast_d = tx_last; txd_d = tx_data[1:0]; txen_d = 1'b1;
    end else if ((tx_state_q == TX_SEND) && strobe) begin
      if (dpos_q != LAST_POS) begin
        dpos_d = dpos_q + 2'd1;
        txd_d  = sh_q[2*dpos_d +: 2];
      end else begin
        txd_d = 2'b00; txen_d = 1'b0; gap_d = '0; urun_d = !tlast_q;
      end
    end else if (tx_state_q == TX_FLUSH) begin
      gap_d = '0;
    end else if ((tx_state_q == TX_GAP) && strobe) begin
      gap_d = gap_q + 1'b1;
    end
  end

  assign phy_txd     = txd_q;
  assign phy_tx_en   = txen_q;
  assign tx_underrun = urun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_q <= 1'b0; cnt_q <= 4'd0; run_q <= 1'b0;
      w_q <= '0; pos_q <= 2'd0; pend_q <= '0; pend_vld_q <= 1'b0; sfd_q <= 1'b0; ferr_q <= 1'b0;
      wp_q <= '0; rp_q <= '0; fcnt_q <= '0; ovf_q <= 1'b0;
      sh_q <= '0; dpos_q <= 2'd0; tlast_q <= 1'b0; txd_q <= 2'b00; txen_q <= 1'b0;
      urun_q <= 1'b0; gap_q <= '0;
    end else begin
      speed_q <= speed_d; cnt_q <= cnt_d; run_q <= 1'b1;
      w_q <= w_d; pos_q <= pos_d; pend_q <= pend_d; pend_vld_q <= pend_vld_d;
      sfd_q <= sfd_d; ferr_q <= ferr_d;
      wp_q <= wp_d; rp_q <= rp_d; fcnt_q <= fcnt_d; ovf_q <= ovf_d;
      sh_q <= sh_d; dpos_q <= dpos_d; tlast_q <= tlast_d; txd_q <= txd_d; txen_q <= txen_d;
      urun_q <= urun_d; gap_q <= gap_d;
    end
  end
endmodule
